// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte port, WAIT_DIV clocks per bit.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a one-byte holding register is used.
module uart_tx #(
    parameter int WAIT_DIV   = 608,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wdata,
    input  logic       wvalid,
    output logic       wready,
    output logic       txd,
    output logic       busy
);

    localparam int CNT_W = $clog2(WAIT_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_DIV - 1);

    if (WAIT_DIV < 2 || WAIT_DIV > 16383) begin : g_bad_div
        $error("uart_tx: WAIT_DIV out of range");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;

    logic       push;
    logic       pop;
    logic       buf_valid;
    logic       buf_next_valid;
    logic [7:0] buf_head;

    assign push = wvalid && wready;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = FIFO_DEPTH[PTR_W:0];

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    // Full blocks writes even when a pop frees a slot on the same edge.
    assign wready         = (count_q != FULL_CNT);
    assign buf_valid      = (count_q != '0);
    assign buf_head       = mem_q[rd_ptr_q];
    assign buf_next_valid = (count_d != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;

    assign wready         = !hold_valid_q;
    assign buf_valid      = hold_valid_q;
    assign buf_head       = hold_q;
    assign buf_next_valid = hold_valid_d;

    // Push needs the flag clear and pop needs it set, so they never coincide.
    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (push) begin
            hold_d       = wdata;
            hold_valid_d = 1'b1;
        end else if (pop) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                cnt_d = '0;
                if (buf_valid) begin
                    pop     = 1'b1;
                    shift_d = buf_head;
                    bit_d   = '0;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    // A waiting byte starts its frame with no idle gap.
                    if (buf_valid) begin
                        pop     = 1'b1;
                        shift_d = buf_head;
                        bit_d   = '0;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE) || buf_next_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
        end
    end

    assign txd  = txd_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at WAIT_DIV=4: a frame-timeline model checked every cycle
// plus hand-computed frame and timing expectations. Works with or without UART_TX_FIFO_EN.
module tb_uart_tx;

    localparam int WD = 4;
`ifdef UART_TX_FIFO_EN
    localparam int CAP   = 16;
    localparam int BURST = 17;
`else
    localparam int CAP   = 1;
    localparam int BURST = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wdata = 8'h00;
    logic       wvalid = 1'b0;
    logic       wready;
    logic       txd;
    logic       busy;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;

    logic [7:0] mQ[$];
    logic [7:0] mCur = 8'h00;
    bit         mActive = 1'b0;
    int         mStart = 0;

    uart_tx #(.WAIT_DIV(WD), .FIFO_DEPTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .wdata (wdata),
        .wvalid(wvalid),
        .wready(wready),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s at cycle %0d: got %b, expected %b", name, cyc, actual, expected);
    endtask

    task automatic checkValue(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    endtask

    // Line level of a frame at a given offset from its start-bit edge.
    function automatic logic frameBit(input logic [7:0] b, input int off);
        int slot;
        slot = off / WD;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        return 1'b1;
    endfunction

    // Model: queue of accepted bytes plus the start edge of the frame on the line.
    always @(posedge clk) begin
        bit acc;
        cyc++;
        if (rst) begin
            mQ.delete();
            mActive = 1'b0;
        end else begin
            acc = wvalid && (mQ.size() != CAP);
            if (mActive && (cyc - mStart) == 10 * WD) mActive = 1'b0;
            if (!mActive && mQ.size() > 0) begin
                mCur    = mQ.pop_front();
                mActive = 1'b1;
                mStart  = cyc;
            end
            if (acc) mQ.push_back(wdata);
        end
        #1;
        checkOutput("model txd", txd, mActive ? frameBit(mCur, cyc - mStart) : 1'b1);
        checkOutput("model busy", busy, mActive || (mQ.size() != 0));
        checkOutput("model wready", wready, mQ.size() != CAP);
    end

    task automatic waitEdge(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge, wvalid still high.
    task automatic applyStimulus(input logic [7:0] d);
        int guard;
        guard = 0;
        wdata  = d;
        wvalid = 1'b1;
        while (!wready && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept wait", wready, 1'b1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic waitIdle();
        for (int g = 0; g < 3000 && busy; g++) @(negedge clk);
        checkOutput("idle wait", busy, 1'b0);
    endtask

    task automatic checkFrame(input string name, input logic [9:0] fr, input int k);
        for (int n = 1; n <= 10 * WD; n++) begin
            waitEdge(k + n);
            checkOutput(name, txd, fr[(n - 1) / WD]);
        end
        checkOutput({name, " busy at stop end"}, busy, 1'b1);
        waitEdge(k + 10 * WD + 1);
        checkOutput({name, " busy after"}, busy, 1'b0);
        checkOutput({name, " idle line"}, txd, 1'b1);
    endtask

    initial begin
        int k;
        int accepted;
        logic [7:0] nextData;

        @(negedge clk);
        checkOutput("reset txd", txd, 1'b1);
        checkOutput("reset wready", wready, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single byte 0x55");
        applyStimulus(8'h55);
        k = cyc;
        wvalid = 1'b0;
        checkOutput("busy after write", busy, 1'b1);
        checkFrame("frame 55", 10'b1_01010101_0, k);

        $display("[TB] back-to-back 0xA5 0x3C");
        applyStimulus(8'hA5);
        k = cyc;
        applyStimulus(8'h3C);
        wvalid = 1'b0;
        waitEdge(k + 40);
        checkOutput("b2b stop end", txd, 1'b1);
`ifdef UART_TX_FIFO_EN
        checkOutput("b2b wready", wready, 1'b1);
`else
        checkOutput("b2b wready", wready, 1'b0);
`endif
        waitEdge(k + 41);
        checkOutput("b2b second start", txd, 1'b0);
        checkOutput("b2b busy", busy, 1'b1);
        waitEdge(k + 80);
        checkOutput("b2b busy end", busy, 1'b1);
        waitEdge(k + 81);
        checkOutput("b2b busy fall", busy, 1'b0);

        $display("[TB] burst until full");
        k = cyc + 1;
        accepted = 0;
        nextData = 8'h00;
        for (int i = 0; i < 21; i++) begin
            wdata  = nextData;
            wvalid = 1'b1;
            if (wready) begin
                accepted++;
                nextData++;
            end
            @(negedge clk);
        end
        wvalid = 1'b0;
        checkValue("burst accepted", accepted, BURST);
        waitEdge(k + 40);
        checkOutput("full before pop", wready, 1'b0);
        waitEdge(k + 41);
        checkOutput("wready after pop", wready, 1'b1);
        waitIdle();

        $display("[TB] reset mid-frame");
        applyStimulus(8'hFF);
        k = cyc;
        wvalid = 1'b0;
        waitEdge(k + 18);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset txd", txd, 1'b1);
        checkOutput("async reset busy", busy, 1'b0);
        checkOutput("async reset wready", wready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(8'h81);
        k = cyc;
        wvalid = 1'b0;
        checkFrame("frame 81", 10'b1_10000001_0, k);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-oriented UART transmitter that serialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) onto `txd`. It pairs with the core's UART receiver and uses the same clocks-per-bit divisor, so both sides of the link agree on baud rate. Bytes arrive from the core over a valid/ready write port into a small TX FIFO that decouples the core from line timing. The FIFO can be compiled out.

## Interface
- `WAIT_DIV`, 608: clock cycles per UART bit; must match the receiver; legal range 2..16383.
- `FIFO_DEPTH`, 16: TX FIFO entries; power of two, ≥2; ignored when the FIFO is compiled out.
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `wdata`  in  8  byte to transmit.
- `wvalid`  in  1  `wdata` valid.
- `wready`  out  1  block can accept a byte this cycle; transfer occurs on a rising edge with `wvalid && wready`.
- `txd`  out  1  serial line, idle high, registered output.
- `busy`  out  1  high while a frame is on the line or any byte is buffered.

## Operation
- **Reset values:** `txd`=1, `wready`=1, `busy`=0, FIFO empty, FSM in IDLE, counters 0.
- **FIFO:**
  - Write pointer, read pointer and count, each with `$clog2(FIFO_DEPTH)+1`-bit count.
  - `wready = (count != FIFO_DEPTH)`.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - Simultaneous push and pop when not full: count unchanged, both pointers advance.
  - When full, `wready`=0, even if a pop happens in the same cycle.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `txd`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, go to START, and drive `txd`←0 on the same edge.
  - **START:** `txd`=0 for WAIT_DIV cycles. Then go to DATA with `txd`←shift[0] and bit index 0.
  - **DATA:** each bit is held WAIT_DIV cycles. On the counter's final cycle, shift right. After bit index 7, go to STOP with `txd`←1.
  - **STOP:** `txd`=1 for WAIT_DIV cycles. On the final cycle:
    - FIFO non-empty: pop and go straight to START, `txd`←0. No idle gap between frames.
    - FIFO empty: go to IDLE.
- **Bit counter:** `$clog2(WAIT_DIV)` bits, counts 0..WAIT_DIV-1, then wraps to 0. It must never exceed WAIT_DIV-1.
- **busy:** `(state != IDLE) || (count != 0)`, registered-equivalent and glitch-free.
- **Reset mid-frame:** the frame is aborted, `txd` returns to 1 immediately (asynchronous), and buffered bytes are discarded.

## Timing
- Byte accepted at edge k with FIFO empty and FSM in IDLE: `txd` falls at edge k+1.
- Frame length is exactly 10×WAIT_DIV cycles, start-bit falling edge to the end of the stop bit.
- Data bit i occupies cycles `[(1+i)·WAIT_DIV, (2+i)·WAIT_DIV)` after the start-bit edge.
- Back-to-back frames: the next start bit begins on the first cycle after the previous stop bit's WAIT_DIV cycles.
- `wready` responds combinationally to FIFO count only, never to `wvalid`.
- `busy` falls on the edge where STOP→IDLE with the FIFO empty.

## Configuration
- **`UART_TX_FIFO_EN` defined:** FIFO of `FIFO_DEPTH` entries as above.
- **`UART_TX_FIFO_EN` undefined:**
  - FIFO replaced by a single holding register with a valid flag; `wready` = !flag.
  - A byte written during a frame is held and starts immediately after the stop bit.
  - All line timing is unchanged.

## Test plan
- **Single byte:** WAIT_DIV=4, write 0x55 at edge 0 → `txd`=0 for cycles 1–4, then the bit sequence 1,0,1,0,1,0,1,0 for 4 cycles each, stop bit high cycles 37–40. `busy` is high from edge 0 until the stop bit ends, then falls.
- **Back-to-back:** write 0xA5 and 0x3C on consecutive cycles → two frames, 80 cycles total at WAIT_DIV=4, second start bit immediately after the first stop bit, no extra idle cycle.
- **FIFO full:** `FIFO_DEPTH`=16, hold `wvalid` high with incrementing data 0x00.. → 17 bytes accepted (one popped at edge 1), then `wready`=0. `wready` reasserts one cycle after each pop. All accepted bytes are transmitted in order with no loss or duplication.
- **Reset mid-frame:** assert `rst` during data bit 3 of 0xFF → `txd`=1 asynchronously, `busy`=0, FIFO empty. The next write 0x81 produces a clean, correct frame.
- **Loopback:** `txd` drives the receiver's `rxd`, WAIT_DIV=608, random 64 bytes → the receiver's `rvalid` pulses 64 times with identical data.
- **Build without `UART_TX_FIFO_EN`:** write 0x12 then 0x34 → `wready` drops after the second write until the first frame's stop bit completes. Both bytes are sent back-to-back.
